// File: rtl/cpu_id.sv
// rtl/cpu_id.sv - RISC-V instruction decode stage with RAW hazard stall (optional WB bypass: CPU_ID_BYPASS_EN)
module cpu_id (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        halt_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] ir_i,
    input  logic        jmp_valid_async_i,
    output logic        ready_async_o,
    output logic [4:0]  rs1_addr_o,
    output logic [4:0]  rs2_addr_o,
    input  logic [31:0] rs1_data_i,
    input  logic [31:0] rs2_data_i,
    input  logic [4:0]  ex_wb_addr_async_i,
    input  logic [4:0]  ma_wb_addr_async_i,
    input  logic [4:0]  wb_wb_addr_async_i,
    input  logic        ex_wb_valid_async_i,
    input  logic        ma_wb_valid_async_i,
    input  logic        wb_wb_valid_async_i,
    input  logic [31:0] wb_wb_data_async_i,
    output logic [31:0] pc_o,
    output logic [31:0] ir_o,
    output logic [31:0] rs1_data_o,
    output logic [31:0] rs2_data_o,
    output logic [31:0] imm_o,
    output logic [4:0]  rd_o,
    output logic        wb_valid_o
);

    localparam logic [31:0] NOP_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_IR = 32'h0000_0013;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    logic        use_rs1;
    logic        use_rs2;
    logic        writes_rd;
    logic [31:0] imm;

    always_comb begin
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        writes_rd = 1'b0;
        imm       = 32'h0;
        case (ir_i[6:0])
            OPC_LUI, OPC_AUIPC: begin
                writes_rd = 1'b1;
                imm       = {ir_i[31:12], 12'b0};
            end
            OPC_JAL: begin
                writes_rd = 1'b1;
                imm       = {{12{ir_i[31]}}, ir_i[19:12], ir_i[20], ir_i[30:21], 1'b0};
            end
            OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_SYSTEM: begin
                use_rs1   = 1'b1;
                writes_rd = 1'b1;
                imm       = {{20{ir_i[31]}}, ir_i[31:20]};
            end
            OPC_BRANCH: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                imm     = {{19{ir_i[31]}}, ir_i[31], ir_i[7], ir_i[30:25], ir_i[11:8], 1'b0};
            end
            OPC_STORE: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                imm     = {{20{ir_i[31]}}, ir_i[31:25], ir_i[11:7]};
            end
            OPC_OP: begin
                use_rs1   = 1'b1;
                use_rs2   = 1'b1;
                writes_rd = 1'b1;
            end
            default: ;
        endcase
    end

    assign rs1_addr_o = ir_i[19:15];
    assign rs2_addr_o = ir_i[24:20];

    // x0 is never a real dependency, so it is masked out before any address match
    logic live1, live2;
    assign live1 = use_rs1 && (rs1_addr_o != 5'd0);
    assign live2 = use_rs2 && (rs2_addr_o != 5'd0);

    logic em1, em2, wm1, wm2;
    assign em1 = (ex_wb_valid_async_i && ex_wb_addr_async_i == rs1_addr_o)
              || (ma_wb_valid_async_i && ma_wb_addr_async_i == rs1_addr_o);
    assign em2 = (ex_wb_valid_async_i && ex_wb_addr_async_i == rs2_addr_o)
              || (ma_wb_valid_async_i && ma_wb_addr_async_i == rs2_addr_o);
    assign wm1 = wb_wb_valid_async_i && wb_wb_addr_async_i == rs1_addr_o;
    assign wm2 = wb_wb_valid_async_i && wb_wb_addr_async_i == rs2_addr_o;

    logic hazard, byp1, byp2;
`ifdef CPU_ID_BYPASS_EN
    // a WB-only match is forwarded; any younger EX/MA match still wins and stalls
    assign byp1   = live1 && wm1 && !em1;
    assign byp2   = live2 && wm2 && !em2;
    assign hazard = (live1 && em1) || (live2 && em2);
`else
    assign byp1   = 1'b0;
    assign byp2   = 1'b0;
    assign hazard = (live1 && (em1 || wm1)) || (live2 && (em2 || wm2));
`endif

    logic [31:0] op1, op2;
    assign op1 = byp1 ? wb_wb_data_async_i : rs1_data_i;
    assign op2 = byp2 ? wb_wb_data_async_i : rs2_data_i;

    assign ready_async_o = !reset_i && !halt_i && !hazard;

    always_ff @(posedge clk_i) begin
        if (reset_i || (!halt_i && (jmp_valid_async_i || hazard))) begin
            pc_o       <= NOP_PC;
            ir_o       <= NOP_IR;
            rs1_data_o <= 32'h0;
            rs2_data_o <= 32'h0;
            imm_o      <= 32'h0;
            rd_o       <= 5'd0;
            wb_valid_o <= 1'b0;
        end else if (!halt_i) begin
            pc_o       <= pc_i;
            ir_o       <= ir_i;
            rs1_data_o <= op1;
            rs2_data_o <= op2;
            imm_o      <= imm;
            rd_o       <= writes_rd ? ir_i[11:7] : 5'd0;
            wb_valid_o <= writes_rd && (ir_i[11:7] != 5'd0);
        end
    end

endmodule

// File: doc/cpu_id.md
Name: cpu_id

Overview:
Risc-V CPU Instruction Decode stage, directly downstream of the instruction fetch stage. Consumes the registered pc/ir pair and reads both source operands from the register file. It extracts rd and the sign-extended immediate, then registers the result for the EX stage. It detects read-after-write hazards against in-flight writes in EX/MA/WB and back-pressures fetch through the async ready signal. When EX jumps, it flushes its output to a NOP.

Parameters:
None. Bubble values are the common package constants NOP_PC and NOP_IR (NOP_IR = 32'h00000013, addi x0,x0,0).

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous, active-high reset
halt_i  in  1  halt; freezes stage outputs
pc_i  in  32  program counter from IF
ir_i  in  32  instruction from IF
jmp_valid_async_i  in  1  EX is redirecting this cycle; flush
ready_async_o  out  1  ID can accept pc_i/ir_i this cycle (combinational)
rs1_addr_o  out  5  regfile read address 1, ir_i[19:15] (combinational)
rs2_addr_o  out  5  regfile read address 2, ir_i[24:20] (combinational)
rs1_data_i  in  32  regfile read data 1 (same-cycle async read)
rs2_data_i  in  32  regfile read data 2
ex_wb_addr_async_i / ma_wb_addr_async_i / wb_wb_addr_async_i  in  5 each  rd of instruction in EX/MA/WB
ex_wb_valid_async_i / ma_wb_valid_async_i / wb_wb_valid_async_i  in  1 each  that stage will write rd
wb_wb_data_async_i  in  32  WB write data (used only with bypass feature)
pc_o  out  32  registered pc to EX
ir_o  out  32  registered instruction to EX
rs1_data_o  out  32  registered operand 1
rs2_data_o  out  32  registered operand 2
imm_o  out  32  registered sign-extended immediate
rd_o  out  5  registered destination register
wb_valid_o  out  1  registered: instruction writes rd and rd != 0

Behaviour:
- Latency is 1 cycle. All outputs are registered on posedge clk_i.
- Source usage by opcode ir_i[6:0]:
  - LUI/AUIPC/JAL: no sources.
  - JALR/LOAD/OP-IMM/SYSTEM: rs1 only.
  - BRANCH/STORE/OP: rs1 and rs2.
  - Unknown opcode: no sources; it passes through undecoded with wb_valid=0.
- Hazard is asserted when a used source is non-zero and equals the addr of any stage whose wb_valid is 1. Register x0 never hazards.
- ready_async_o = ~reset_i & ~halt_i & ~hazard. It does not depend on jmp_valid_async_i; IF already ignores ready during a jump.
- Immediate is selected by format:
  - I: ir[31:20] sign-extended.
  - S: {ir[31:25], ir[11:7]}.
  - B: {ir[31], ir[7], ir[30:25], ir[11:8], 0}.
  - U: {ir[31:12], 12'b0}.
  - J: {ir[31], ir[19:12], ir[20], ir[30:21], 0}.
  - All sign-extended from bit 31. R-type and unknown opcodes give 0.
- Output register update, in priority order:
  1. reset_i: pc_o=NOP_PC, ir_o=NOP_IR, rs1/rs2/imm=0, rd_o=0, wb_valid_o=0.
  2. halt_i: all outputs hold.
  3. jmp_valid_async_i: bubble (same values as reset). This takes priority over hazard and over new input.
  4. hazard: bubble is emitted downstream. IF holds pc_i/ir_i because ready is low, and the same instruction is re-evaluated next cycle.
  5. Otherwise: capture the decoded pc_i/ir_i/operands/imm/rd/wb_valid.
- Reset mid-stall: the bubble is output and the stall state is abandoned; ready stays 0 while reset_i is high.
- Bubble input from IF (ir_i=NOP_IR) decodes as a normal addi x0 with wb_valid_o=0 (rd=0). No special case is needed.
- Simultaneous hazard on rs1 and rs2 against different stages: still a single stall. The stage stalls until no hazard remains (at most 3 cycles).

Optional Feature:
Macro CPU_ID_BYPASS_EN.
- Defined: a source matching only the WB stage (not EX or MA) does not hazard. Its operand is taken from wb_wb_data_async_i instead of the regfile. If EX/MA also match, the stage still stalls.
- Undefined: WB matches stall like the others, and wb_wb_data_async_i is unused.

Test Plan:
- Reset held 2 cycles, then released: pc_o=NOP_PC, ir_o=32'h00000013, wb_valid_o=0, ready_async_o=0 during reset and 1 after.
- pc_i=0x100, ir_i=0xFFF00093 (addi x1,x0,-1), no hazards -> next cycle pc_o=0x100, imm_o=0xFFFFFFFF, rd_o=1, wb_valid_o=1.
- ir_i=add x3,x1,x2 with ex_wb_addr=1/valid=1 for 1 cycle -> ready_async_o=0 and a NOP is output that cycle. Next cycle, with the hazard cleared, the add is issued with rs1_data_o=rs1_data_i.
- jmp_valid_async_i=1 together with a hazard and a valid instruction -> NOP is output and no hazard stall is recorded.
- halt_i=1 for 3 cycles mid-stream -> all outputs unchanged and ready_async_o=0.
- Bypass: wb_wb_addr=5/valid=1, wb_wb_data=0xDEADBEEF, ir_i=addi x6,x5,1 -> with CPU_ID_BYPASS_EN, rs1_data_o=0xDEADBEEF and no stall. Without the macro, 1 stall cycle.
